// File: rtl/stage_skid.sv
// stage_skid: one pipeline stage with valid/stall handshakes on both sides.
// The stage holds up to two words: an output register and a skid register.
// When the next stage stalls, the skid register takes one word that is
// already in flight, so o_stall comes straight from a flop and has no
// combinational path from i_stall.
// Each captured word has INCR added to it. o_xfer_cnt counts words handed
// to the next stage.
//
// Handshake rules:
//   accept = i_valid & ~o_stall   (a word moves in from stage n-1)
//   drain  = o_valid & ~i_stall   (a word moves out to stage n+1)
// While o_valid=1 and i_stall=1, o_data does not change.
// When o_valid=0, o_data holds its last value and downstream ignores it.
module stage_skid #(
    parameter int DATA_W = 16,
    parameter int INCR   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_stall,
    input  logic              i_stall,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_xfer_cnt,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] INCR_W = DATA_W'(INCR);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               drain;
    logic [DATA_W-1:0]  in_inc;

    // Handshake terms; valid and stall are pure functions of the state register
    always_comb begin
        o_valid = (state_q != ST_EMPTY);
        o_stall = (state_q == ST_FULL);
        accept  = i_valid & ~o_stall;
        drain   = o_valid & ~i_stall;
        in_inc  = i_data + INCR_W;
    end

    // Next state and datapath; a flush voids any accept or drain in its cycle
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            if (drain) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_BUSY;
                        out_d   = in_inc;
                    end
                end
                ST_BUSY: begin
                    if (accept && drain) begin
                        out_d = in_inc;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_inc;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d = ST_BUSY;
                        out_d   = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, data and counter registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output mapping
    always_comb begin
        o_data      = out_q;
        o_xfer_cnt  = cnt_q;
        o_dbg_state = state_q;
    end

endmodule

// File: tb/tb_stage_skid.sv
// Bench for stage_skid. Two instances share every input: one uses a 16-bit
// counter and one uses a 4-bit counter, for the wrap case.
// The driver process issues directed vectors. The monitor runs on the falling
// edge. It keeps an occupancy model as a queue of expected words and checks
// flags, data order, data stability under stall, and both counters.
module tb_stage_skid;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_stall;

  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_stall;
  logic [CW-1:0] o_cnt;
  logic [1:0]    o_st;

  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_stall;
  logic [3:0]    w_cnt;
  logic [1:0]    w_st;

  int total;
  int bad;

  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt;
  logic          started;
  logic          hold_chk;
  logic [DW-1:0] hold_val;

  stage_skid #(.DATA_W(DW), .INCR(1), .CNT_W(CW)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_data(in_data), .i_valid(in_valid),
    .o_stall(o_stall), .i_stall(in_stall), .o_data(o_data), .o_valid(o_valid),
    .o_xfer_cnt(o_cnt), .o_dbg_state(o_st)
  );

  stage_skid #(.DATA_W(DW), .INCR(1), .CNT_W(4)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_data(in_data), .i_valid(in_valid),
    .o_stall(w_stall), .i_stall(in_stall), .o_data(w_data), .o_valid(w_valid),
    .o_xfer_cnt(w_cnt), .o_dbg_state(w_st)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    in_stall = s;
  endtask

  // scoreboard / monitor: check outputs against the model, then advance the model
  always @(negedge clk) begin
    logic mv;
    logic ms;
    logic [DW-1:0] front;
    mv = (exp_q.size() != 0);
    ms = (exp_q.size() == 2);
    if (started) begin
      chk("o_valid", {31'd0, o_valid}, {31'd0, mv});
      chk("o_stall", {31'd0, o_stall}, {31'd0, ms});
      chk("state", {30'd0, o_st}, {30'd0, ms ? 2'd2 : (mv ? 2'd1 : 2'd0)});
      chk("xfer_cnt", {16'd0, o_cnt}, {16'd0, exp_cnt});
      chk("wrap_cnt", {28'd0, w_cnt}, {28'd0, exp_cnt[3:0]});
      chk("wrap_valid", {31'd0, w_valid}, {31'd0, mv});
      chk("wrap_stall", {31'd0, w_stall}, {31'd0, ms});
      if (hold_chk) chk("stall_stable", {16'd0, o_data}, {16'd0, hold_val});
    end
    if (rst) begin
      exp_q.delete();
      exp_cnt  = '0;
      hold_chk = 1'b0;
      started  = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      hold_chk = 1'b0;
    end else begin
      if (mv && !in_stall) begin
        front = exp_q.pop_front();
        chk("drain_data", {16'd0, o_data}, {16'd0, front});
        chk("wrap_data", {16'd0, w_data}, {16'd0, front});
        exp_cnt = exp_cnt + 1'b1;
      end
      if (in_valid && !ms) exp_q.push_back(in_data + 16'd1);
      hold_chk = mv & in_stall;
      hold_val = o_data;
    end
  end

  initial begin
    logic [CW-1:0] cnt_snap;
    total    = 0;
    bad      = 0;
    exp_cnt  = '0;
    started  = 1'b0;
    hold_chk = 1'b0;
    hold_val = '0;
    rst      = 1'b1;
    flush    = 1'b0;
    drive(1'b1, 16'h1234, 1'b0);

    // 1 reset held two cycles with i_valid high
    step();
    step();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_data", {16'd0, o_data}, 32'd0);
    chk("rst_cnt", {16'd0, o_cnt}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    step();

    // 2 stream 0x0010..0x0014
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0010 + 16'(i), 1'b0);
      step();
      chk("stream_data", {16'd0, o_data}, 32'h0011 + i);
    end
    drive(1'b0, 16'h0, 1'b0);
    step();
    chk("stream_cnt", {16'd0, o_cnt}, 32'd5);

    // 3 skid: stall once the first word is out
    drive(1'b1, 16'h0100, 1'b0);
    step();
    chk("skid_first", {16'd0, o_data}, 32'h0101);
    drive(1'b1, 16'h0101, 1'b1);
    step();
    chk("skid_stall", {31'd0, o_stall}, 32'd1);
    chk("skid_hold", {16'd0, o_data}, 32'h0101);
    drive(1'b1, 16'h0102, 1'b1);
    step();
    step();
    chk("skid_hold2", {16'd0, o_data}, 32'h0101);
    drive(1'b1, 16'h0102, 1'b0);
    step();
    chk("skid_rel1", {16'd0, o_data}, 32'h0102);
    step();
    chk("skid_rel2", {16'd0, o_data}, 32'h0103);
    drive(1'b0, 16'h0, 1'b0);
    step();
    step();

    // 4 flush while FULL, then a fresh word
    drive(1'b1, 16'h0200, 1'b1);
    step();
    drive(1'b1, 16'h0201, 1'b1);
    step();
    chk("full_stall", {31'd0, o_stall}, 32'd1);
    flush = 1'b1;
    drive(1'b1, 16'h0202, 1'b1);
    step();
    flush = 1'b0;
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_stall", {31'd0, o_stall}, 32'd0);
    drive(1'b1, 16'h00AA, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0);
    chk("post_flush", {16'd0, o_data}, 32'h00AB);
    step();
    // a flush in a cycle with a pending drain does not count it
    drive(1'b1, 16'h0300, 1'b0);
    step();
    cnt_snap = o_cnt;
    flush = 1'b1;
    drive(1'b0, 16'h0, 1'b0);
    step();
    flush = 1'b0;
    chk("flush_nocnt", {16'd0, o_cnt}, {16'd0, cnt_snap});

    // 5 wrap: data 0xFFFF and 17 transfers on the 4-bit counter
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 16'hFFFF + 16'(i), 1'b0);
      step();
      if (i == 0) chk("data_wrap", {16'd0, o_data}, 32'h0000);
    end
    drive(1'b0, 16'h0, 1'b0);
    step();
    chk("cnt_wrap4", {28'd0, w_cnt}, 32'd1);
    chk("cnt_17", {16'd0, o_cnt}, 32'd17);

    // 6 mixed valid/stall/flush traffic against the scoreboard
    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            ($urandom_range(0, 2) == 0));
      flush = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 511) == 0);
      step();
    end
    flush = 1'b0;
    rst   = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    step();
    step();
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
